mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum ACCESS cycles to wait for mem_ready before aborting.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port core_req  input  1  core (control-unit side) transaction request; held until core_ack.
REQ-005 SHALL have port core_we  input  1  core write (1) / read (0).
REQ-006 SHALL have ports core_addr, core_wdata  input  32 each  core address and write data.
REQ-007 SHALL have ports core_rdata  output  32  and core_ack  output  1  core read data and one-cycle completion strobe.
REQ-008 SHALL have ports dbg_req, dbg_we  input  1 each  and dbg_addr, dbg_wdata  input  32 each  debug/loader request set, same meaning as core.
REQ-009 SHALL have ports dbg_rdata  output  32  and dbg_ack  output  1  debug read data and completion strobe.
REQ-010 SHALL have ports mem_en, mem_we  output  1 each  and mem_addr, mem_wdata  output  32 each  shared single-port memory request.
REQ-011 SHALL have ports mem_rdata  input  32  and mem_ready  input  1  memory read data and completion.
REQ-012 SHALL have ports err  output  1  (timeout strobe, coincident with ack) and busy  output  1  (high in ACCESS and DONE).

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-014 IDLE: if neither req is high, remain IDLE; otherwise latch winner's we/addr/wdata and grant id, clear wait counter, go ACCESS next cycle.
REQ-015 Arbitration: single requester wins; both high -> grant the requester not granted last (last_grant register, updated on each grant).
REQ-016 ACCESS: mem_en=1, mem_we/mem_addr/mem_wdata driven from latched values, constant for the whole state; requester inputs ignored.
REQ-017 ACCESS with mem_ready=1: capture mem_rdata into granted requester's rdata register (reads only; writes leave rdata unchanged), go DONE.
REQ-018 ACCESS with mem_ready=0: increment 4-bit-or-wider wait counter; when counter equals TIMEOUT-1 and mem_ready still 0, go DONE with error flag set, rdata of granted requester set to 32'h0 for reads.
REQ-019 DONE: exactly one cycle; assert ack of granted requester only, assert err if error flag set; mem_en=0; go IDLE.
REQ-020 Latency: req sampled in IDLE at edge N -> mem_en from cycle N+1; mem_ready sampled at edge M -> ack high in cycle M+1; zero-wait access gives ack 3 cycles after req seen.
REQ-021 Requester SHALL drop or change req at the edge ending its ack cycle; req still high in IDLE is a new transaction.
REQ-022 Outside ACCESS: mem_en=0, mem_we=0; mem_addr/mem_wdata hold last latched values.
REQ-023 core_rdata/dbg_rdata SHALL hold their last value until overwritten by a completed read of that requester.
REQ-024 mem_ready while not in ACCESS SHALL be ignored.
REQ-025 Request arriving in DONE is not sampled until the following IDLE cycle; no back-to-back grant without IDLE.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, core_ack=0, dbg_ack=0, err=0, busy=0, core_rdata=0, dbg_rdata=0, wait counter=0, error flag=0, last_grant=dbg (core wins first tie).
REQ-027 Reset during ACCESS SHALL abandon the transaction with no ack and no err after release; first post-reset cycle is IDLE.

Verification
REQ-028 Core read, zero wait: core_req=1, we=0, addr=0x10; mem_ready=1 first ACCESS cycle with mem_rdata=0xA5A5_0001 -> mem_en one cycle, core_ack one cycle later, core_rdata=0xA5A50001, dbg_ack=0, err=0.
REQ-029 Tie after reset: core and dbg requests at same edge -> core granted first (mem_addr=core_addr); dbg held, granted after core DONE+IDLE; both acked once each.
REQ-030 Fairness: both requesting continuously for 4 transactions -> grants alternate core, dbg, core, dbg.
REQ-031 Wait states: dbg write addr=0x40 data=0x1234_5678, mem_ready after 5 ACCESS cycles -> mem_en/mem_we/mem_addr/mem_wdata stable 6 cycles, dbg_ack after, dbg_rdata unchanged.
REQ-032 Timeout: core read, mem_ready never high -> exactly 15 ACCESS cycles, then core_ack=1 and err=1 same cycle, core_rdata=0.
REQ-033 Reset mid-ACCESS: rst_n low in 2nd ACCESS cycle -> mem_en drops immediately, no ack/err after release, busy=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter (core, debug) onto one shared single-port memory
module mem_port_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_ack,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err,
  output logic        busy
);

  localparam int CW = ($clog2(TIMEOUT) > 4) ? $clog2(TIMEOUT) : 4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          last_grant;  // 0 = core, 1 = dbg
  logic          grant_id;
  logic          lat_we;
  logic          pick_dbg;

  // On a tie the requester that did not win last time gets the port
  assign pick_dbg = dbg_req & (~core_req | ~last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      lat_we     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_ack   <= 1'b0;
      dbg_ack    <= 1'b0;
      core_rdata <= '0;
      dbg_rdata  <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (core_req || dbg_req) begin
            grant_id   <= pick_dbg;
            last_grant <= pick_dbg;
            lat_we     <= pick_dbg ? dbg_we : core_we;
            mem_we     <= pick_dbg ? dbg_we : core_we;
            mem_addr   <= pick_dbg ? dbg_addr : core_addr;
            mem_wdata  <= pick_dbg ? dbg_wdata : core_wdata;
            mem_en     <= 1'b1;
            busy       <= 1'b1;
            wait_cnt   <= '0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_ready || wait_cnt == CW'(TIMEOUT - 1)) begin
            // Timed-out reads return zero so stale data is never mistaken for a result
            if (!lat_we) begin
              if (grant_id) dbg_rdata  <= mem_ready ? mem_rdata : 32'h0;
              else          core_rdata <= mem_ready ? mem_rdata : 32'h0;
            end
            err      <= ~mem_ready;
            core_ack <= ~grant_id;
            dbg_ack  <= grant_id;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DONE: begin
          core_ack <= 1'b0;
          dbg_ack  <= 1'b0;
          err      <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
